// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared constants and types for the instruction-fetch stage.
//   INST_NOP            - canonical bubble instruction (addi x0,x0,0)
//   IF_RESET_PC_DEFAULT - default first-fetch word address (byte 0x1000)
//   if_state_e          - fetch FSM states
//   pc_inc()            - sequential word-PC increment, wraps modulo 2^32
package if_stage_pkg;

  localparam logic [31:0] INST_NOP            = 32'h0000_0013;
  localparam logic [31:0] IF_RESET_PC_DEFAULT = 32'h0000_0400;

  typedef enum logic [1:0] {
    IF_BOOT  = 2'd0,
    IF_RUN   = 2'd1,
    IF_HOLD  = 2'd2,
    IF_FLUSH = 2'd3
  } if_state_e;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// if_perf_cnt: fetch-stage performance counters (built only with IF_PERF_CNT_EN).
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   fetch_inc_i   - an instruction was accepted by ID this cycle
//   flush_inc_i   - a redirect was accepted this cycle
//   fetch_cnt_o   - accepted-instruction count, wraps modulo 2^32
//   flush_cnt_o   - accepted-redirect count, wraps modulo 2^32
module if_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_inc_i,
  input  logic        flush_inc_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
);

  logic [31:0] fetch_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= '0;
      flush_q <= '0;
    end else begin
      if (fetch_inc_i) fetch_q <= fetch_q + 32'd1;
      if (flush_inc_i) flush_q <= flush_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage feeding ID.
// Owns the word-addressed PC, drives a synchronous IMEM read port (data one
// cycle after address) and presents {inst, pc, valid} to ID. A one-entry hold
// buffer keeps the presented instruction across ID stalls; redirects squash
// the in-flight fetch as a NOP bubble.
// Optional feature macro: IF_PERF_CNT_EN adds fetch_cnt_o / flush_cnt_o.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   stall_i          - ID did not accept inst_o this cycle
//   redirect_i       - taken branch / jump, load redirect_addr_i
//   redirect_addr_i  - redirect target (word address)
//   imem_en_o        - IMEM read enable
//   imem_addr_o      - IMEM word address (low IMEM_AW bits of pc_q)
//   imem_rdata_i     - IMEM read data
//   inst_o           - instruction to ID
//   pc_data_o        - word PC of inst_o
//   inst_valid_o     - inst_o is a real instruction
//   fetch_cnt_o      - (IF_PERF_CNT_EN) accepted instructions
//   flush_cnt_o      - (IF_PERF_CNT_EN) accepted redirects
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC_DEFAULT,
  parameter int unsigned IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_addr_i,
  output logic               imem_en_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_rdata_i,
  output logic [31:0]        inst_o,
  output logic [31:0]        pc_data_o,
  output logic               inst_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt_o,
  output logic [31:0]        flush_cnt_o
`endif
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] hold_q, hold_d;
  logic        redir_acc;
  logic        advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IF_BOOT;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      hold_q   <= INST_NOP;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      hold_q   <= hold_d;
    end
  end

  // ID cannot produce a redirect before the first valid instruction, so
  // BOOT ignores it.
  assign redir_acc = redirect_i && (state_q != IF_BOOT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_out_d     = pc_out_q;
    hold_d       = hold_q;
    inst_o       = INST_NOP;
    inst_valid_o = 1'b0;
    advance      = 1'b0;

    unique case (state_q)
      IF_BOOT: begin
        advance = 1'b1;
      end
      IF_RUN: begin
        inst_o       = imem_rdata_i;
        inst_valid_o = 1'b1;
        if (stall_i) begin
          hold_d  = imem_rdata_i;
          state_d = IF_HOLD;
        end else begin
          advance = 1'b1;
        end
      end
      IF_HOLD: begin
        // IMEM keeps re-reading pc_q, so on release the RUN data is already
        // the word following the held one.
        inst_o       = hold_q;
        inst_valid_o = 1'b1;
        advance      = !stall_i;
      end
      IF_FLUSH: begin
        advance = !stall_i;
      end
      default: ;
    endcase

    // Redirect outranks stall; held instruction is dropped.
    if (redir_acc) begin
      pc_d    = redirect_addr_i;
      hold_d  = INST_NOP;
      state_d = IF_FLUSH;
    end else if (advance) begin
      pc_out_d = pc_q;
      pc_d     = pc_inc(pc_q);
      state_d  = IF_RUN;
    end
  end

  assign pc_data_o   = pc_out_q;
  assign imem_addr_o = pc_q[IMEM_AW-1:0];
  // No IMEM activity while reset is held.
  assign imem_en_o   = rst_n;

`ifdef IF_PERF_CNT_EN
  logic fetch_inc;
  assign fetch_inc = inst_valid_o & ~stall_i & ~redirect_i;

  if_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_inc_i (fetch_inc),
    .flush_inc_i (redir_acc),
    .fetch_cnt_o (fetch_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC   = 32'h0000_0400;
  localparam logic [31:0] WBASE = 32'hA000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        imem_en_o;
  logic [13:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] pc_data_o;
  logic        inst_valid_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  int unsigned n_vec;
  int unsigned n_err;

  if_stage #(
    .RESET_PC (RPC),
    .IMEM_AW  (14)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .imem_en_o       (imem_en_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .inst_o          (inst_o),
    .pc_data_o       (pc_data_o),
    .inst_valid_o    (inst_valid_o)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt_o     (fetch_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous IMEM: word k holds 0xA000_0000 + k.
  initial imem_rdata_i = '0;
  always @(posedge clk)
    if (imem_en_o) imem_rdata_i <= WBASE + {18'b0, imem_addr_o};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Model of what ID sees: a shown instruction (or bubble) per cycle.
  logic        m_boot, m_bub, m_valid;
  logic [31:0] m_pc, m_tgt, m_fc, m_fl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot = 1'b1; m_bub = 1'b0; m_valid = 1'b0;
      m_pc = '0; m_tgt = '0; m_fc = '0; m_fl = '0;
    end else begin
      if (m_valid && !stall_i && !redirect_i) m_fc = m_fc + 1;
      if (m_boot) begin
        m_boot = 1'b0; m_valid = 1'b1; m_pc = RPC;
      end else if (redirect_i) begin
        m_fl = m_fl + 1; m_bub = 1'b1; m_valid = 1'b0; m_tgt = redirect_addr_i;
      end else if (m_bub) begin
        if (!stall_i) begin m_bub = 1'b0; m_valid = 1'b1; m_pc = m_tgt; end
      end else if (!stall_i) begin
        m_pc = m_pc + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] nxt, e_addr, e_inst;
    nxt    = m_boot ? RPC : (m_bub ? m_tgt : m_pc + 1);
    e_addr = {18'b0, nxt[13:0]};
    e_inst = m_valid ? WBASE + {18'b0, m_pc[13:0]} : NOP;
    chk("valid", {31'b0, inst_valid_o}, {31'b0, m_valid});
    chk("inst",  inst_o, e_inst);
    chk("pc",    pc_data_o, m_pc);
    chk("addr",  {18'b0, imem_addr_o}, e_addr);
    chk("en",    {31'b0, imem_en_o}, {31'b0, rst_n});
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt_o, m_fc);
    chk("flush_cnt", flush_cnt_o, m_fl);
`endif
  end

  // Advance into the next cycle with the given inputs; returns mid-cycle.
  task automatic cyc(input logic s, input logic r, input logic [31:0] a);
    @(posedge clk); #1;
    stall_i = s; redirect_i = r; redirect_addr_i = a;
    @(negedge clk); #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("L boot addr",  {18'b0, imem_addr_o}, 32'h400);
    chk("L boot valid", {31'b0, inst_valid_o}, 32'd0);
    cyc(0, 0, 0);
    chk("L c2 inst", inst_o, 32'hA000_0400);
    chk("L c2 pc",   pc_data_o, 32'h400);
    cyc(0, 0, 0);
    chk("L c3 pc", pc_data_o, 32'h401);
    // stall three cycles while 0x402 is shown
    cyc(1, 0, 0); chk("L st1 pc", pc_data_o, 32'h402);
    cyc(1, 0, 0);
    cyc(1, 0, 0); chk("L st3 inst", inst_o, 32'hA000_0402);
    cyc(0, 0, 0); chk("L rel pc", pc_data_o, 32'h402);
    cyc(0, 0, 0); chk("L after1", pc_data_o, 32'h403);
    cyc(0, 0, 0); chk("L after2", pc_data_o, 32'h404);
    // redirect to 0x800 while showing 0x405
    cyc(0, 1, 32'h800); chk("L r pc", pc_data_o, 32'h405);
    cyc(0, 0, 0);
    chk("L bub valid", {31'b0, inst_valid_o}, 32'd0);
    chk("L bub inst",  inst_o, 32'h13);
    cyc(0, 0, 0); chk("L tgt pc", pc_data_o, 32'h800);
    cyc(0, 0, 0); chk("L tgt+1",  pc_data_o, 32'h801);
    // redirect + stall together during HOLD
    cyc(1, 0, 0);
    cyc(1, 1, 32'h900);
    cyc(1, 0, 0); chk("L hf valid", {31'b0, inst_valid_o}, 32'd0);
    cyc(1, 0, 0); chk("L hf addr",  {18'b0, imem_addr_o}, 32'h900);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("L hf pc",   pc_data_o, 32'h900);
    chk("L hf inst", inst_o, 32'hA000_0900);
    // back-to-back redirects: newest target wins
    cyc(0, 1, 32'hA00);
    cyc(0, 1, 32'hB00);
    cyc(0, 0, 0);
    cyc(0, 0, 0); chk("L newest", pc_data_o, 32'hB00);
    // wrap of the IMEM index
    cyc(0, 1, 32'h3FFF);
    cyc(0, 0, 0); chk("L w addr0", {18'b0, imem_addr_o}, 32'h3FFF);
    cyc(0, 0, 0);
    chk("L w pc0",   pc_data_o, 32'h3FFF);
    chk("L w addr1", {18'b0, imem_addr_o}, 32'h0);
    cyc(0, 0, 0);
    chk("L w pc1",   pc_data_o, 32'h4000);
    chk("L w inst1", inst_o, 32'hA000_0000);
    // asynchronous reset mid-HOLD
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("L ar valid", {31'b0, inst_valid_o}, 32'd0);
    chk("L ar pc",    pc_data_o, 32'd0);
    chk("L ar inst",  inst_o, NOP);
`ifdef IF_PERF_CNT_EN
    chk("L ar fc", fetch_cnt_o, 32'd0);
    chk("L ar fl", flush_cnt_o, 32'd0);
`endif
    @(posedge clk); #1;
    // redirect during BOOT must be ignored
    stall_i = 1'b0; redirect_i = 1'b1; redirect_addr_i = 32'h700;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("L rb addr", {18'b0, imem_addr_o}, 32'h400);
    cyc(0, 0, 0); chk("L rb pc", pc_data_o, 32'h400);
    for (int unsigned i = 0; i < 9; i++) cyc(0, 0, 0);
    cyc(0, 1, 32'h100);
    cyc(0, 1, 32'h200);
    cyc(0, 0, 0);
    cyc(0, 0, 0); chk("L perf pc", pc_data_o, 32'h200);
`ifdef IF_PERF_CNT_EN
    chk("L perf fc", fetch_cnt_o, 32'd10);
    chk("L perf fl", flush_cnt_o, 32'd2);
`endif
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
